// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST controller: FSM states,
// LFSR/MISR feedback tap masks, default seed and golden signature.
package c17_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_COMPARE,
    ST_DONE
  } state_t;

  // Tap masks: the feedback bit is the XOR of the register bits selected here
  localparam logic [4:0] LFSR_POLY  = 5'b1_0100;     // x^5 + x^3 + 1 -> q[4]^q[2]
  localparam logic [7:0] MISR_POLY  = 8'b1000_1110;  // m[7]^m[3]^m[2]^m[1]

  localparam logic [4:0] DEF_SEED   = 5'b00001;
  localparam logic [7:0] DEF_GOLDEN = 8'h00;

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register: shift left with parity feedback,
// XOR the parallel input into the low bits. load clears, en absorbs.
module c17_misr #(
  parameter int unsigned           W    = 8,
  parameter int unsigned           IN_W = 2,
  parameter logic        [W-1:0]   TAPS = 8'b1000_1110
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            en,
  input  logic [IN_W-1:0] din,
  output logic [W-1:0]    q
);

  logic [W-1:0] q_next;

  always_comb begin
    q_next = {q[W-2:0], ^(q & TAPS)} ^ W'(din);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= '0;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST controller for the c17 benchmark: LFSR pattern source, MISR response
// compaction, final signature compare, and functional-mode input bypass.
module c17_bist_ctrl
  import c17_bist_pkg::*;
#(
  parameter int unsigned        PI_W       = 5,
  parameter int unsigned        PO_W       = 2,
  parameter int unsigned        MISR_W     = 8,
  parameter int unsigned        NUM_PAT    = 32,
  parameter logic [PI_W-1:0]    LFSR_SEED  = PI_W'(DEF_SEED),
  parameter logic [MISR_W-1:0]  GOLDEN_SIG = MISR_W'(DEF_GOLDEN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [PI_W-1:0]   func_in,
  output logic [PI_W-1:0]   cut_in,
  input  logic [PO_W-1:0]   cut_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam int unsigned     CNT_W  = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(NUM_PAT - 1);
  localparam logic [CNT_W-1:0] PENULT = CNT_W'(NUM_PAT - 2);

  state_t             state;
  logic [PI_W-1:0]    lfsr;
  logic [PI_W-1:0]    lfsr_step;
  logic [CNT_W-1:0]   cnt;
  logic               misr_load;
  logic               misr_en;
  logic [MISR_W-1:0]  misr_q;

  assign lfsr_step = {lfsr[PI_W-2:0], ^(lfsr & PI_W'(LFSR_POLY))};
  assign cut_in    = (state == ST_RUN) ? lfsr : func_in;
  assign signature = misr_q;

  // MISR control mirrors the FSM transitions below so both update on the same edge
  always_comb begin
    misr_load = 1'b0;
    misr_en   = 1'b0;
    if (abort) begin
      misr_load = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: misr_load = start;
        ST_RUN:           misr_en   = ~pause;
        default:          ;
      endcase
    end
  end

  c17_misr #(
    .W    (MISR_W),
    .IN_W (PO_W),
    .TAPS (MISR_W'(MISR_POLY))
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (misr_load),
    .en    (misr_en),
    .din   (cut_out),
    .q     (misr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      lfsr  <= LFSR_SEED;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else if (abort) begin
      state <= ST_IDLE;
      lfsr  <= LFSR_SEED;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            lfsr  <= LFSR_SEED;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!pause) begin
            // Final pattern is forced to all-zero so the default run is exhaustive
            lfsr <= (cnt == PENULT) ? '0 : lfsr_step;
            if (cnt == LAST) begin
              state <= ST_COMPARE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        ST_COMPARE: begin
          pass  <= (misr_q == GOLDEN_SIG);
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Scoreboard bench for c17_bist_ctrl: a pattern-index reference model pushes
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_c17_bist_ctrl;

  localparam int unsigned NUM_PAT = 32;

  function automatic logic [1:0] c17_fn(input logic [4:0] x);
    logic n1, n2, n3, n6, n7, g10, g11, g16, g19, g22, g23;
    n1 = x[0]; n2 = x[1]; n3 = x[2]; n6 = x[3]; n7 = x[4];
    g10 = ~(n1 & n3);
    g11 = ~(n3 & n6);
    g16 = ~(n2 & g11);
    g19 = ~(g11 & n7);
    g22 = ~(g10 & g16);
    g23 = ~(g16 & g19);
    return {g23, g22};
  endfunction

  function automatic logic [4:0] lfsr_fn(input logic [4:0] p);
    return {p[3:0], p[4] ^ p[2]};
  endfunction

  function automatic logic [7:0] misr_fn(input logic [7:0] m, input logic [1:0] d);
    logic fb;
    fb = m[7] ^ m[3] ^ m[2] ^ m[1];
    return {m[6:0], fb} ^ {6'b0, d};
  endfunction

  function automatic logic [7:0] ref_golden();
    logic [4:0] p;
    logic [7:0] m;
    p = 5'b00001;
    m = 8'h00;
    for (int k = 0; k < 32; k++) begin
      m = misr_fn(m, c17_fn((k == 31) ? 5'b00000 : p));
      p = lfsr_fn(p);
    end
    return m;
  endfunction

  localparam logic [7:0] GOLD     = ref_golden();
  localparam logic [7:0] GOLD_BAD = GOLD ^ 8'h01;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, pause;
  logic [4:0] func_in, cut_in, cut_in_b;
  logic [1:0] cut_out, cut_out_b;
  logic       busy, done, pass, busy_b, done_b, pass_b;
  logic [7:0] signature, signature_b;
  bit         use_c17;

  always #5 clk = ~clk;

  always_comb begin
    cut_out   = use_c17 ? c17_fn(cut_in)   : cut_in[1:0];
    cut_out_b = use_c17 ? c17_fn(cut_in_b) : cut_in_b[1:0];
  end

  c17_bist_ctrl #(.GOLDEN_SIG(GOLD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .func_in(func_in), .cut_in(cut_in), .cut_out(cut_out),
    .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  c17_bist_ctrl #(.GOLDEN_SIG(GOLD_BAD)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
    .func_in(func_in), .cut_in(cut_in_b), .cut_out(cut_out_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(signature_b)
  );

  // ---------------- reference model ----------------
  typedef enum {PH_IDLE, PH_RUN, PH_CMP, PH_DONE} phase_t;
  typedef struct {
    int         cyc;
    logic       busy, done, pass, pass_b;
    logic [4:0] cut_in;
    logic [7:0] sig;
  } exp_t;

  logic [4:0] pat [NUM_PAT];
  phase_t     ph;
  int         idx;
  logic [7:0] msig;
  logic       mp, mpb;
  exp_t       sbq [$];
  int         cyc_no = 0;
  int         checks = 0;
  int         errors = 0;

  function automatic logic [1:0] cut_fn(input logic [4:0] x);
    return use_c17 ? c17_fn(x) : x[1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, c, act, exp);
    end
  endtask

  task automatic model_reset();
    ph = PH_IDLE; idx = 0; msig = 8'h00; mp = 1'b0; mpb = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit p);
    if (a) begin
      model_reset();
    end else begin
      case (ph)
        PH_IDLE: if (s) begin ph = PH_RUN; idx = 0; msig = 8'h00; end
        PH_RUN: if (!p) begin
          msig = misr_fn(msig, cut_fn(pat[idx]));
          idx++;
          if (idx == NUM_PAT) ph = PH_CMP;
        end
        PH_CMP: begin mp = (msig == GOLD); mpb = (msig == GOLD_BAD); ph = PH_DONE; end
        PH_DONE: if (s) begin ph = PH_RUN; idx = 0; msig = 8'h00; mp = 1'b0; mpb = 1'b0; end
        default: ;
      endcase
    end
  endtask

  // One clock: drive inputs, record expected outputs of this cycle, advance model
  task automatic cyc(input bit s, input bit a, input bit p, input logic [4:0] f);
    exp_t e;
    start = s; abort = a; pause = p; func_in = f;
    e.cyc    = cyc_no;
    e.busy   = (ph == PH_RUN) || (ph == PH_CMP);
    e.done   = (ph == PH_DONE);
    e.pass   = mp;
    e.pass_b = mpb;
    e.cut_in = (ph == PH_RUN) ? pat[idx] : f;
    e.sig    = msig;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    cyc_no++;
    model_step(s, a, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 5'($urandom));
  endtask

  task automatic hw_reset();
    rst_n = 1'b0; start = 0; abort = 0; pause = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk("busy",        32'(busy),        32'(e.busy),   e.cyc);
      chk("done",        32'(done),        32'(e.done),   e.cyc);
      chk("pass",        32'(pass),        32'(e.pass),   e.cyc);
      chk("cut_in",      32'(cut_in),      32'(e.cut_in), e.cyc);
      chk("signature",   32'(signature),   32'(e.sig),    e.cyc);
      chk("pass_badsig", 32'(pass_b),      32'(e.pass_b), e.cyc);
      chk("sig_badsig",  32'(signature_b), 32'(e.sig),    e.cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] p;
    p = 5'b00001;
    for (int k = 0; k < NUM_PAT; k++) begin
      pat[k] = (k == NUM_PAT - 1) ? 5'b00000 : p;
      p = lfsr_fn(p);
    end
    use_c17 = 1'b0;
    func_in = 5'b0;
    model_reset();
    hw_reset();
    idle(3);

    // stub CUT: full pattern sequence
    cyc(1, 0, 0, 5'($urandom));
    idle(38);

    // real c17: pass expected, bad-golden copy must fail with same signature
    use_c17 = 1'b1;
    cyc(1, 0, 0, 5'($urandom));
    idle(38);

    // pause 3 cycles mid-run
    cyc(1, 0, 0, 5'($urandom));
    idle(11);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 5'($urandom));
    idle(30);

    // abort at t+10, then a fresh run
    cyc(1, 0, 0, 5'($urandom));
    idle(9);
    cyc(0, 1, 0, 5'($urandom));
    idle(3);
    cyc(1, 0, 0, 5'($urandom));
    idle(38);

    // start ignored in RUN (t+5), re-arm from DONE
    cyc(1, 0, 0, 5'($urandom));
    idle(4);
    cyc(1, 0, 0, 5'($urandom));
    idle(32);
    cyc(1, 0, 0, 5'($urandom));
    idle(38);

    // randomized traffic: pauses, spurious starts, occasional aborts
    for (int r = 0; r < 6; r++) begin
      if (ph != PH_RUN) use_c17 = 1'($urandom);
      cyc(1, 0, 0, 5'($urandom));
      for (int i = 0; i < 45; i++) begin
        cyc(($urandom_range(9) == 0), ($urandom_range(79) == 0),
            ($urandom_range(4) == 0), 5'($urandom));
      end
    end

    // async reset mid-run
    cyc(1, 0, 0, 5'($urandom));
    idle(15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 32'(busy),      32'(0),      cyc_no);
    chk("async_done", 32'(done),      32'(0),      cyc_no);
    chk("async_pass", 32'(pass),      32'(0),      cyc_no);
    chk("async_sig",  32'(signature), 32'(0),      cyc_no);
    chk("async_cut",  32'(cut_in),    32'(func_in), cyc_no);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 0, 0, 5'b10110);
    cyc(0, 0, 1, 5'b10110);
    cyc(1, 0, 0, 5'b10110);
    idle(38);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
